// File: rtl/reg_file_mp.sv
// Multi-ported integer register file with per-register pending (scoreboard) bits,
// configurable read/write port count and same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*AW-1:0]     wr_addr_i,
    input  logic [NWR*XLEN-1:0]   wr_data_i,
    input  logic                  rsv_en_i,
    input  logic [AW-1:0]         rsv_addr_i,
    input  logic                  flush_i,
    output logic [NREGS-1:0]      busy_o
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_pend;

    logic [NREGS-1:0] w_wen;
    logic [XLEN-1:0]  w_wdata [NREGS];
    logic [NREGS-1:0] w_pend_next;

    // Ascending port scan: the last matching (highest-index) port wins.
    always_comb begin
        w_wen = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_wdata[r] = r_mem[r];
        end
        for (int k = 0; k < NWR; k++) begin
            if (wr_en_i[k] && (!ZR || wr_addr_i[k*AW +: AW] != '0)) begin
                w_wen[wr_addr_i[k*AW +: AW]]   = 1'b1;
                w_wdata[wr_addr_i[k*AW +: AW]] = wr_data_i[k*XLEN +: XLEN];
            end
        end
    end

    // Reserve overrides a same-cycle write (new producer); flush overrides everything.
    always_comb begin
        w_pend_next = r_pend & ~w_wen;
        if (rsv_en_i && (!ZR || rsv_addr_i != '0)) begin
            w_pend_next[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            w_pend_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wen[r]) begin
                    r_mem[r] <= w_wdata[r];
                end
            end
            r_pend <= w_pend_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic            w_fwd;
            logic [XLEN-1:0] w_rdata;

            assign w_addr = rd_addr_i[gi*AW +: AW];

            // Forwarding is suppressed during reset so outputs read 0 while rst_ni is low.
            always_comb begin
                w_fwd   = 1'b0;
                w_rdata = r_mem[w_addr];
                if (BP && rst_ni && (!ZR || w_addr != '0)) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == w_addr) begin
                            w_fwd   = 1'b1;
                            w_rdata = wr_data_i[k*XLEN +: XLEN];
                        end
                    end
                end
            end

            assign rd_data_o[gi*XLEN +: XLEN] = w_rdata;
            assign rd_busy_o[gi]              = r_pend[w_addr] & ~w_fwd;
        end
    endgenerate

    assign busy_o = r_pend;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations, then a long
// randomized run checked every cycle against an array-based reference model.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 3;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_ni;

    logic [AW-1:0]   rd_addr [NRD];
    logic [NWR-1:0]  wr_en;
    logic [AW-1:0]   wr_addr [NWR];
    logic [XLEN-1:0] wr_data [NWR];
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;

    logic [NRD*AW-1:0]   rd_addr_flat;
    logic [NRD*XLEN-1:0] rd_data_flat;
    logic [NRD-1:0]      rd_busy;
    logic [NWR*AW-1:0]   wr_addr_flat;
    logic [NWR*XLEN-1:0] wr_data_flat;
    logic [NREGS-1:0]    busy;

    // Reference model state
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_pend;

    int errors = 0;
    int checks = 0;

    always #5 if (clk_en) clk = ~clk;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rpack
            assign rd_addr_flat[gi*AW +: AW] = rd_addr[gi];
        end
        for (genvar gi = 0; gi < NWR; gi++) begin : g_wpack
            assign wr_addr_flat[gi*AW +: AW]     = wr_addr[gi];
            assign wr_data_flat[gi*XLEN +: XLEN] = wr_data[gi];
        end
    endgenerate

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rd_addr_i  (rd_addr_flat),
        .rd_data_o  (rd_data_flat),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr_flat),
        .wr_data_i  (wr_data_flat),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_o     (busy)
    );

    function automatic logic [XLEN-1:0] rdd(int j);
        return rd_data_flat[j*XLEN +: XLEN];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_pend = '0;
    endtask

    // Outputs as the rules dictate from model state plus the inputs currently applied.
    task automatic compare_model();
        logic [XLEN-1:0] ed;
        logic            eb;
        for (int j = 0; j < NRD; j++) begin
            ed = m_mem[rd_addr[j]];
            eb = m_pend[rd_addr[j]];
            if (rd_addr[j] == 0 || !rst_ni) begin
                ed = '0;
                eb = 1'b0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && wr_addr[k] == rd_addr[j]) begin
                        ed = wr_data[k];
                        eb = 1'b0;
                    end
                end
            end
            chk($sformatf("rd_data[%0d]", j), rdd(j), ed);
            chk($sformatf("rd_busy[%0d]", j), {31'b0, rd_busy[j]}, {31'b0, eb});
        end
        chk("busy_o", busy, m_pend);
    endtask

    task automatic model_edge();
        if (flush) begin
            m_pend = '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_addr[k] != 0) m_pend[wr_addr[k]] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wr_addr[k] != 0) m_mem[wr_addr[k]] = wr_data[k];
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            wr_addr[k] = '0;
            wr_data[k] = '0;
        end
        rsv_addr = '0;
    endtask

    task automatic settle();
        #1;
        compare_model();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_ni) model_edge();
        @(negedge clk);
    endtask

    initial begin
        // Reset with no clock running
        rst_ni = 1'b0;
        idle();
        for (int j = 0; j < NRD; j++) rd_addr[j] = '0;
        model_clear();
        #3;
        for (int a = 0; a < NREGS; a++) begin
            rd_addr[0] = AW'(a);
            #1;
            chk($sformatf("reset_rd_x%0d", a), rdd(0), 32'h0);
        end
        chk("reset_busy_o", busy, 32'h0);

        clk_en = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;

        // Two ports write x5 in the same cycle: port1 wins, forwarded immediately
        idle();
        wr_en = 3'b011;
        wr_addr[0] = 5; wr_data[0] = 32'hDEAD_BEEF;
        wr_addr[1] = 5; wr_data[1] = 32'h1234_5678;
        rd_addr[0] = 5;
        settle();
        chk("t2_bypass_x5", rdd(0), 32'h1234_5678);
        advance();
        idle();
        settle();
        chk("t2_stored_x5", rdd(0), 32'h1234_5678);
        advance();

        // x0 ignores writes and reservations
        wr_en = 3'b001; wr_addr[0] = 0; wr_data[0] = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 0; rd_addr[0] = 0;
        settle();
        chk("t3_x0_same_cycle", rdd(0), 32'h0);
        advance();
        idle();
        settle();
        chk("t3_x0_data", rdd(0), 32'h0);
        chk("t3_x0_busy", {31'b0, busy[0]}, 32'h0);
        advance();

        // Reserve x7, then write it: busy drops in the write cycle via forwarding
        rsv_en = 1'b1; rsv_addr = 7;
        settle();
        advance();
        idle();
        rd_addr[0] = 7;
        settle();
        chk("t4_busy_o7_set", {31'b0, busy[7]}, 32'h1);
        chk("t4_rd_busy_set", {31'b0, rd_busy[0]}, 32'h1);
        wr_en = 3'b001; wr_addr[0] = 7; wr_data[0] = 32'h42;
        settle();
        chk("t4_rd_busy_fwd", {31'b0, rd_busy[0]}, 32'h0);
        chk("t4_rd_data_fwd", rdd(0), 32'h42);
        advance();
        idle();
        settle();
        chk("t4_busy_o7_clr", {31'b0, busy[7]}, 32'h0);
        chk("t4_x7_stored", rdd(0), 32'h42);
        advance();

        // Reserve wins over same-cycle write; flush wins over reserve
        rsv_en = 1'b1; rsv_addr = 9;
        wr_en = 3'b100; wr_addr[2] = 9; wr_data[2] = 32'h99;
        settle();
        advance();
        idle();
        rd_addr[1] = 9;
        settle();
        chk("t5_busy_o9", {31'b0, busy[9]}, 32'h1);
        chk("t5_x9_data", rdd(1), 32'h99);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 3;
        settle();
        advance();
        idle();
        settle();
        chk("t5_flush_all", busy, 32'h0);
        advance();

        // Randomized run with occasional asynchronous reset pulses
        for (int c = 0; c < 10000; c++) begin
            rst_ni = 1'b1;
            for (int j = 0; j < NRD; j++)
                rd_addr[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            for (int k = 0; k < NWR; k++) begin
                wr_en[k]   = ($urandom_range(0, 2) == 0);
                wr_addr[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
                wr_data[k] = $urandom;
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_ni = 1'b0;
                model_clear();
            end
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
